// File: rtl/cdim_fetch_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package cdim_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_e;

    localparam logic [31:0] FETCH_ALIGN_MASK = 32'hffff_fff8;
    localparam logic [31:0] RESET_PC         = 32'hbfc0_0000;

    // First delivered word: upper half when the fetch pc sits at +4 of the 8-byte line.
    function automatic logic [31:0] word_sel(input logic [63:0] line, input logic upper);
        return upper ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/if_fetch_hold.sv
// One-entry holding register for a fetch response that arrived while the inst FIFO was full.
module if_fetch_hold (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        clear,
    input  logic [63:0] load_data,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [63:0] data,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding 8-byte fetch, stale-response drop, one-deep hold.
// Optional perf counters (perf_drop_cnt, perf_hold_cnt) are built when IF_FETCH_PERF_EN is defined.
module if_fetch_ctrl
    import cdim_fetch_pkg::*;
`ifdef IF_FETCH_PERF_EN
#(
    parameter int PERF_W = 32
)
`endif
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_curr,
    input  logic        fifo_full,
    input  logic        is_except,
    input  logic        branch_taken,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        inst_data_ok1,
    output logic        inst_data_ok2,
    output logic [31:0] inst_rdata1,
    output logic [31:0] inst_rdata2,
    output logic [31:0] inst_pc1,
    output logic        inst_adel,
    output logic        pc_en,
    output logic [2:0]  dbg_state
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_drop_cnt,
    output logic [PERF_W-1:0] perf_hold_cnt
`endif
);

    // Bus handshake: a request is accepted on a cycle with inst_req & inst_addr_ok; inst_req may
    // be withdrawn before acceptance. inst_data_ok is a single-cycle response with no back-pressure.
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic         redirect, deliver, pc_load, hold_load, hold_clear;
    logic         hold_valid;
    logic [63:0]  hold_data, sel_data;
    logic [31:0]  hold_pc, sel_pc;

    assign redirect  = is_except | branch_taken;
    assign sel_data  = hold_valid ? hold_data : inst_rdata;
    assign sel_pc    = hold_valid ? hold_pc : pc_q;
    assign inst_addr = inst_req ? (pc_curr & FETCH_ALIGN_MASK) : 32'h0;
    assign pc_en     = resetn & (inst_data_ok1 | redirect);
    assign dbg_state = state_q;

    if_fetch_hold u_hold (
        .clk       (clk),
        .resetn    (resetn),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_data (inst_rdata),
        .load_pc   (pc_q),
        .valid     (hold_valid),
        .data      (hold_data),
        .pc        (hold_pc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pc_load) pc_q <= pc_curr;
        end
    end

    always_comb begin
        state_d       = state_q;
        inst_req      = 1'b0;
        inst_data_ok1 = 1'b0;
        inst_data_ok2 = 1'b0;
        inst_rdata1   = '0;
        inst_rdata2   = '0;
        inst_pc1      = '0;
        inst_adel     = 1'b0;
        deliver       = 1'b0;
        pc_load       = 1'b0;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // resetn gates IDLE so every output is low while reset is held
                if (resetn && !redirect && !fifo_full) begin
                    if (pc_curr[1:0] != 2'b00) begin
                        inst_data_ok1 = 1'b1;
                        inst_adel     = 1'b1;
                        inst_pc1      = pc_curr;
                    end else begin
                        inst_req = 1'b1;
                        pc_load  = inst_addr_ok;
                        state_d  = inst_addr_ok ? ST_WAIT : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    state_d = ST_IDLE;
                end else begin
                    inst_req = 1'b1;
                    if (inst_addr_ok) begin
                        pc_load = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    if (redirect) begin
                        state_d = ST_IDLE;
                    end else if (fifo_full) begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (redirect) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    hold_clear = 1'b1;
                    state_d    = ST_IDLE;
                end else if (!fifo_full) begin
                    deliver    = 1'b1;
                    hold_clear = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (inst_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (deliver) begin
            inst_data_ok1 = 1'b1;
            inst_data_ok2 = ~sel_pc[2];
            inst_rdata1   = word_sel(sel_data, sel_pc[2]);
            inst_rdata2   = sel_data[63:32];
            inst_pc1      = sel_pc;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic drop;
    assign drop = (state_q == ST_DISCARD && inst_data_ok) ||
                  (state_q == ST_WAIT && inst_data_ok && redirect) ||
                  (state_q == ST_HOLD && redirect);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_drop_cnt <= '0;
            perf_hold_cnt <= '0;
        end else begin
            if (drop) perf_drop_cnt <= perf_drop_cnt + PERF_W'(1);
            if (state_q == ST_HOLD) perf_hold_cnt <= perf_hold_cnt + PERF_W'(1);
        end
    end
`endif

endmodule
